// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with double-buffered image,
// anti-ghost blanking, BCD/hex decode, leading-zero suppression and per-digit blanking.
module seg7_scan_driver #(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 10000,
  parameter int BLANK_CYC = 16,
  parameter int HEX_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  frame_start
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [CW:0]   BLANK_V  = (CW+1)'(BLANK_CYC);

  logic [CW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   pend_dig, act_dig;
  logic [N_DIGITS-1:0]     pend_dp, act_dp, pend_blank, act_blank;
  logic                    pend_lz, act_lz;

  logic                    slot_wrap, frame_wrap, in_blank;
  logic [3:0]              cur_code;
  logic                    cur_dp, cur_blank, cur_supp, zero_run;
  logic [7:0]              pat;
  logic [7:0]              seg_nxt;
  logic [N_DIGITS-1:0]     sel_nxt;

  function automatic logic [7:0] decode(input logic [3:0] code);
    logic hex;
    hex = (HEX_EN != 0);
    case (code)
      4'h0: decode = 8'hFC;
      4'h1: decode = 8'h60;
      4'h2: decode = 8'hDA;
      4'h3: decode = 8'hF2;
      4'h4: decode = 8'h66;
      4'h5: decode = 8'hB6;
      4'h6: decode = 8'hBE;
      4'h7: decode = 8'hE4;
      4'h8: decode = 8'hFE;
      4'h9: decode = 8'hF6;
      4'hA: decode = hex ? 8'hEE : 8'h00;
      4'hB: decode = hex ? 8'h3E : 8'h00;
      4'hC: decode = hex ? 8'h9C : 8'h00;
      4'hD: decode = hex ? 8'h7A : 8'h00;
      4'hE: decode = hex ? 8'h9E : 8'h00;
      default: decode = hex ? 8'h8E : 8'h00;
    endcase
  endfunction

  assign slot_wrap  = (div_cnt == DIV_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  assign in_blank   = ({1'b0, div_cnt} < BLANK_V);

  // Suppression runs from the top digit down; zero_run drops at the first nonzero code.
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    zero_run  = act_lz;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (act_dig[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        cur_code  = act_dig[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = act_blank[k];
        cur_supp  = zero_run && (k != 0);
      end
    end
    pat = decode(cur_code);
    if (in_blank) begin
      sel_nxt = '0;
      seg_nxt = 8'h00;
    end else begin
      sel_nxt = N_DIGITS'(1) << idx;
      seg_nxt = cur_blank ? 8'h00 : {(cur_supp ? 7'h00 : pat[7:1]), cur_dp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      pend_dig    <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_lz     <= 1'b0;
      act_dig     <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      act_lz      <= 1'b0;
      seg_out     <= 8'h00;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (slot_wrap) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      if (load) begin
        pend_dig   <= digits_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_lz    <= lz_en;
      end
      // A load on the wrap cycle bypasses pending so it is not lost for a frame.
      if (frame_wrap) begin
        act_dig   <= load ? digits_in : pend_dig;
        act_dp    <= load ? dp_in     : pend_dp;
        act_blank <= load ? blank_in  : pend_blank;
        act_lz    <= load ? lz_en     : pend_lz;
      end
      seg_out     <= seg_nxt;
      dig_sel     <= sel_nxt;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized + directed bench for seg7_scan_driver; two instances cover HEX_EN=0 and HEX_EN=1.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = SD * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  sel0, sel1;
  logic        fs0, fs1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(0)) u_dec (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg_out(seg0), .dig_sel(sel0), .frame_start(fs0));

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .HEX_EN(1)) u_hex (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg_out(seg1), .dig_sel(sel1), .frame_start(fs1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: cycle count since reset plus pending/active images.
  int          t = 0;
  logic [15:0] m_pd = 0, m_ad = 0;
  logic [3:0]  m_pdp = 0, m_adp = 0, m_pb = 0, m_ab = 0;
  logic        m_plz = 0, m_alz = 0;

  function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] dp,
                                         input logic [3:0] bl, input logic lz,
                                         input int k, input bit hex);
    logic [127:0] tbl;
    logic [3:0]   code;
    logic [7:0]   p;
    int           top_nz;
    tbl = {8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
           8'hE4, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};
    top_nz = -1;
    for (int j = 0; j < N; j++) if (d[4*j +: 4] != 4'h0) top_nz = j;
    code = d[4*k +: 4];
    if (bl[k]) return 8'h00;
    p = (code > 4'd9 && !hex) ? 8'h00 : tbl[8*code +: 8];
    if (lz && k > top_nz && k != 0) p = 8'h00;
    return {p[7:1], dp[k]};
  endfunction

  task automatic cycle();
    logic [7:0] e0, e1;
    logic [3:0] es;
    logic       ef;
    int         dv, ix;
    if (rst) begin
      e0 = 0; e1 = 0; es = 0; ef = 0; t = 0;
      m_pd = 0; m_ad = 0; m_pdp = 0; m_adp = 0; m_pb = 0; m_ab = 0; m_plz = 0; m_alz = 0;
    end else begin
      dv = t % SD;
      ix = (t / SD) % N;
      ef = ((t % FRAME) == FRAME - 1);
      es = (dv < BC) ? 4'h0 : 4'(1 << ix);
      e0 = (dv < BC) ? 8'h00 : ref_seg(m_ad, m_adp, m_ab, m_alz, ix, 1'b0);
      e1 = (dv < BC) ? 8'h00 : ref_seg(m_ad, m_adp, m_ab, m_alz, ix, 1'b1);
      if (ef) begin
        m_ad  = load ? digits_in : m_pd;
        m_adp = load ? dp_in     : m_pdp;
        m_ab  = load ? blank_in  : m_pb;
        m_alz = load ? lz_en     : m_plz;
      end
      if (load) begin
        m_pd = digits_in; m_pdp = dp_in; m_pb = blank_in; m_plz = lz_en;
      end
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    check("seg_out", 32'(seg0), 32'(e0));
    check("seg_out_hex", 32'(seg1), 32'(e1));
    check("dig_sel", 32'(sel0), 32'(es));
    check("dig_sel_hex", 32'(sel1), 32'(es));
    check("frame_start", 32'(fs0), 32'(ef));
    check("frame_start_hex", 32'(fs1), 32'(ef));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz);
    digits_in = d; dp_in = dp; blank_in = bl; lz_en = lz; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic align(input int ph);
    int guard;
    guard = 0;
    while ((t % FRAME) != ph && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(3);

    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    run(40);
    do_load(16'h0050, 4'b0100, 4'b0000, 1'b1);
    run(36);
    do_load(16'h000A, 4'b0000, 4'b0000, 1'b0);
    run(36);
    do_load(16'h000A, 4'b0000, 4'b0001, 1'b0);
    run(36);

    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    run(20);
    align(9);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    run(36);

    align(15);
    do_load(16'h8765, 4'b0011, 4'b0000, 1'b0);
    run(20);

    do_load(16'h00F0, 4'b1000, 4'b0000, 1'b1);
    run(2);
    do_load(16'h0003, 4'b0001, 4'b0000, 1'b1);
    run(36);

    align(9);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(40);

    repeat (40) begin
      for (int j = 0; j < N; j++)
        rd[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      do_load(rd, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
              1'($urandom_range(0, 1)));
      run($urandom_range(0, 20));
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
